// File: rtl/tdm_demux2_pkg.sv
// rtl/tdm_demux2_pkg.sv - shared TDM slot indices and demux FSM encodings
package tdm_demux2_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    EXP0 = 2'd1,
    EXP1 = 2'd2
  } tdm_state_t;

  // Slot indices are also used by the transmit-side mux select.
  localparam logic SLOT_A0 = 1'b0;
  localparam logic SLOT_A1 = 1'b1;

  function automatic logic slot_of(input logic sync);
    return sync ? SLOT_A0 : SLOT_A1;
  endfunction

endpackage

// File: rtl/tdm_demux2_if.sv
// rtl/tdm_demux2_if.sv - multiplexed input stream and split channel outputs
interface tdm_demux2_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic             d_sync;
  logic [WIDTH-1:0] y0;
  logic [WIDTH-1:0] y1;
  logic             y_valid;
  logic             locked;
  logic             sync_err;

  modport master (
    output d, d_valid, d_sync,
    input  y0, y1, y_valid, locked, sync_err
  );

  modport slave (
    input  d, d_valid, d_sync,
    output y0, y1, y_valid, locked, sync_err
  );

endinterface

// File: rtl/tdm_demux2.sv
// rtl/tdm_demux2.sv - two-slot TDM demultiplexer with sync lock and slip detection
module tdm_demux2
  import tdm_demux2_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  tdm_demux2_if.slave       bus
);

  tdm_state_t       state;
  logic [WIDTH-1:0] hold0;
  logic [WIDTH-1:0] y0_q;
  logic [WIDTH-1:0] y1_q;
  logic             y_valid_q;
  logic             locked_q;
  logic             sync_err_q;
  logic             slot;

  assign slot = slot_of(bus.d_sync);

  // hold0 keeps the channel-0 sample so y0/y1 only ever update as a pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      hold0      <= '0;
      y0_q       <= '0;
      y1_q       <= '0;
      y_valid_q  <= 1'b0;
      locked_q   <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      y_valid_q  <= 1'b0;
      sync_err_q <= 1'b0;
      if (bus.d_valid) begin
        case (state)
          HUNT: begin
            if (slot == SLOT_A0) begin
              hold0    <= bus.d;
              state    <= EXP1;
              locked_q <= 1'b1;
            end
          end
          EXP1: begin
            if (slot == SLOT_A1) begin
              y0_q      <= hold0;
              y1_q      <= bus.d;
              y_valid_q <= 1'b1;
              state     <= EXP0;
            end else begin
              // Early sync: restart the pair from this sample.
              hold0      <= bus.d;
              sync_err_q <= 1'b1;
            end
          end
          EXP0: begin
            if (slot == SLOT_A0) begin
              hold0 <= bus.d;
              state <= EXP1;
            end else begin
              sync_err_q <= 1'b1;
              locked_q   <= 1'b0;
              state      <= HUNT;
            end
          end
          default: begin
            state    <= HUNT;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.y0       = y0_q;
  assign bus.y1       = y1_q;
  assign bus.y_valid  = y_valid_q;
  assign bus.locked   = locked_q;
  assign bus.sync_err = sync_err_q;

endmodule

// File: tb/tb_tdm_demux2.sv
// tb/tb_tdm_demux2.sv - directed vector bench for tdm_demux2
module tb_tdm_demux2;

  logic clk = 1'b0;
  logic rst;

  tdm_demux2_if #(.WIDTH(4)) bus ();

  tdm_demux2 #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       valid;
    logic       sync;
    logic [3:0] d;
    logic [3:0] y0;
    logic [3:0] y1;
    logic       y_valid;
    logic       locked;
    logic       sync_err;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic s, input logic [3:0] dd);
    rst         = r;
    bus.d_valid = v;
    bus.d_sync  = s;
    bus.d       = dd;
  endtask

  task automatic check_all(input string tag, input logic [3:0] e0, input logic [3:0] e1,
                           input logic ev, input logic el, input logic ee);
    check({tag, ".y0"}, bus.y0, e0);
    check({tag, ".y1"}, bus.y1, e1);
    check({tag, ".y_valid"}, {3'b0, bus.y_valid}, {3'b0, ev});
    check({tag, ".locked"}, {3'b0, bus.locked}, {3'b0, el});
    check({tag, ".sync_err"}, {3'b0, bus.sync_err}, {3'b0, ee});
  endtask

  initial begin
    // rst valid sync d | y0 y1 yv lk se  (state after the edge)
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 4'h3, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 4'hA, 4'h3, 4'hA, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 4'h5, 4'h3, 4'hA, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 4'hC, 4'h5, 4'hC, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 4'h7, 4'h5, 4'hC, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 4'hE, 4'h7, 4'hE, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 4'hF, 4'h7, 4'hE, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 4'hF, 4'h7, 4'hE, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 4'h1, 4'h7, 4'hE, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 4'h2, 4'h7, 4'hE, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 4'h4, 4'h7, 4'hE, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 4'h6, 4'h4, 4'h6, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 4'h1, 4'h4, 4'h6, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 4'h9, 4'h4, 4'h6, 1'b0, 1'b1, 1'b1};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 4'hB, 4'h9, 4'hB, 1'b1, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 1'b1, 4'h8, 4'h9, 4'hB, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 1'b1, 1'b1, 4'h2, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 4'h2, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 1'b1, 4'h5, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};

    drive(1'b1, 1'b0, 1'b0, 4'h0);
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].sync, vecs[i].d);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].y0, vecs[i].y1,
                vecs[i].y_valid, vecs[i].locked, vecs[i].sync_err);
      @(negedge clk);
    end

    // Idle gap inside a pair: the pair completes late and pulses exactly once.
    drive(1'b0, 1'b1, 1'b1, 4'h5);
    @(posedge clk); #1;
    check_all("gap_ch0", 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b0, 4'hD);
      @(posedge clk); #1;
      check_all($sformatf("gap_idle%0d", k), 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
    end
    drive(1'b0, 1'b1, 1'b0, 4'h6);
    @(posedge clk); #1;
    check_all("gap_ch1", 4'h5, 4'h6, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    @(posedge clk); #1;
    check_all("gap_after", 4'h5, 4'h6, 1'b0, 1'b1, 1'b0);
    @(negedge clk);

    // Reset with a sync sample present must win and leave HUNT.
    drive(1'b1, 1'b1, 1'b1, 4'h7);
    @(posedge clk); #1;
    check_all("rst_over_sync", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 4'h3);
    @(posedge clk); #1;
    check_all("post_rst_ch1", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
